// File: rtl/rxll_frame_rd.sv
// Read-side frame sequencer: pops SATA rx FIFO words and emits whole
// LocalLink frames, with SOF/EOF framing, truncation and per-frame status.
module rxll_frame_rd #(
  parameter int C_MAX_WORDS   = 2049,
  parameter int C_CNT_WIDTH   = 12,
  parameter int C_CUT_THROUGH = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [35:0]            fifo_do,
  input  logic                   fifo_empty,
  input  logic                   fifo_almost_empty,
  input  logic                   fifo_eof_rdy,
  output logic                   fifo_rd_en,
  output logic [31:0]            ll_data,
  output logic                   ll_sof_n,
  output logic                   ll_eof_n,
  output logic                   ll_src_rdy_n,
  input  logic                   ll_dst_rdy_n,
  output logic                   frm_done,
  output logic [C_CNT_WIDTH-1:0] frm_len,
  output logic                   frm_err,
  output logic                   frm_ovf,
  output logic                   frm_drop
);

  typedef enum logic [1:0] {
    IDLE,
    XFER,
    DROP,
    STAT
  } state_t;

  localparam logic [C_CNT_WIDTH-1:0] MAXW =
    C_CNT_WIDTH'(C_MAX_WORDS);
  localparam logic CT = (C_CUT_THROUGH != 0);

  state_t                 state;
  logic [C_CNT_WIDTH-1:0] cnt;
  logic [C_CNT_WIDTH-1:0] cnt_nxt;
  logic                   last_ld;
  logic                   f_err;
  logic                   f_ovf;
  logic                   f_drop;
  logic                   beat;
  logic                   hit_max;
  logic                   start_ok;
  logic                   fin_xfer;
  logic                   go_stat;
  logic                   unused_bit;

  assign unused_bit = fifo_do[32];

  always_comb begin
    beat     = ~ll_src_rdy_n & ~ll_dst_rdy_n;
    start_ok = fifo_eof_rdy | (CT & ~fifo_almost_empty);
    cnt_nxt  = (cnt == MAXW) ? cnt : cnt + 1'b1;
    hit_max  = (cnt_nxt == MAXW);
    fifo_rd_en = 1'b0;
    unique case (state)
      XFER: fifo_rd_en = ~fifo_empty
                       & (ll_src_rdy_n | beat)
                       & ~last_ld;
      DROP: fifo_rd_en = ~fifo_empty;
      default: fifo_rd_en = 1'b0;
    endcase
    fin_xfer = (state == XFER) & beat & ~ll_eof_n;
    go_stat  = (fin_xfer & ~f_ovf)
             | ((state == DROP) & fifo_rd_en & fifo_do[34]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      last_ld      <= 1'b0;
      f_err        <= 1'b0;
      f_ovf        <= 1'b0;
      f_drop       <= 1'b0;
      ll_data      <= '0;
      ll_sof_n     <= 1'b1;
      ll_eof_n     <= 1'b1;
      ll_src_rdy_n <= 1'b1;
      frm_done     <= 1'b0;
      frm_len      <= '0;
      frm_err      <= 1'b0;
      frm_ovf      <= 1'b0;
      frm_drop     <= 1'b0;
    end else begin
      frm_done <= 1'b0;
      if (go_stat) begin
        frm_done <= 1'b1;
        frm_len  <= cnt;
        frm_err  <= f_err;
        frm_ovf  <= f_ovf;
        frm_drop <= f_drop;
      end
      unique case (state)
        IDLE: begin
          if (!fifo_empty) begin
            if (!fifo_do[35]) begin
              state  <= DROP;
              f_drop <= 1'b1;
            end else if (start_ok) begin
              state <= XFER;
            end
          end
        end
        XFER: begin
          if (fifo_rd_en) begin
            ll_src_rdy_n <= 1'b0;
            ll_data      <= fifo_do[31:0];
            ll_sof_n     <= ~(cnt == '0);
            ll_eof_n     <= ~(fifo_do[34] | hit_max);
            cnt          <= cnt_nxt;
            if ((cnt != '0) && fifo_do[35])
              f_err <= 1'b1;
            // EOF wins over truncation when both land on the same word
            if (fifo_do[34]) begin
              last_ld <= 1'b1;
              if (fifo_do[33])
                f_err <= 1'b1;
            end else if (hit_max) begin
              last_ld <= 1'b1;
              f_ovf   <= 1'b1;
            end
          end else if (beat) begin
            ll_src_rdy_n <= 1'b1;
            ll_sof_n     <= 1'b1;
            ll_eof_n     <= 1'b1;
          end
          if (fin_xfer)
            state <= f_ovf ? DROP : STAT;
        end
        DROP: begin
          if (fifo_rd_en && fifo_do[34])
            state <= STAT;
        end
        STAT: begin
          state   <= IDLE;
          cnt     <= '0;
          last_ld <= 1'b0;
          f_err   <= 1'b0;
          f_ovf   <= 1'b0;
          f_drop  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
